// File: rtl/rr_sched_pkg.sv
// rtl/rr_sched_pkg.sv - shared constants and helpers for the slot-table scheduler
package rr_sched_pkg;

  // Scheduling modes selected by the mode input
  localparam logic MODE_STRICT = 1'b0;
  localparam logic MODE_WC     = 1'b1;

  // Default slot table content: slot i serves channel i mod nch
  function automatic int default_id(input int slot, input int nch);
    return slot % nch;
  endfunction

endpackage

// File: rtl/rr_slot_picker.sv
// rtl/rr_slot_picker.sv - combinational rotate-priority slot search
module rr_slot_picker
  import rr_sched_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int SLOTS = 10,
  parameter int IDW   = $clog2(NCH),
  parameter int SW    = $clog2(SLOTS)
) (
  input  logic [SLOTS-1:0][IDW-1:0] tbl,
  input  logic [SW:0]               len,
  input  logic [SW-1:0]             ptr,
  input  logic [NCH-1:0]            empty,
  input  logic                      mode,
  output logic                      hit,
  output logic [SW-1:0]             sel
);

  logic [SW-1:0] start;
  int            idx;

  // IDs outside the channel range are treated as permanently empty
  function automatic logic avail(input logic [IDW-1:0] id, input logic [NCH-1:0] emp);
    return (int'(id) < NCH) && !emp[id];
  endfunction

  // Strict mode looks at one slot; work-conserving walks len slots from the pointer with wrap
  always_comb begin
    hit   = 1'b0;
    idx   = 0;
    start = ({1'b0, ptr} >= len) ? '0 : ptr;
    sel   = start;
    if (mode == MODE_STRICT) begin
      hit = avail(tbl[start], empty);
    end else begin
      for (int k = 0; k < SLOTS; k++) begin
        if (!hit && k < int'(len)) begin
          idx = int'(start) + k;
          if (idx >= int'(len)) idx = idx - int'(len);
          if (avail(tbl[SW'(idx)], empty)) begin
            hit = 1'b1;
            sel = SW'(idx);
          end
        end
      end
    end
  end

endmodule

// File: rtl/rr_slot_scheduler.sv
// rtl/rr_slot_scheduler.sv - slot-table round-robin pop scheduler for the FIFO bank
module rr_slot_scheduler
  import rr_sched_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int SLOTS = 10,
  parameter int IDW   = $clog2(NCH),
  parameter int SW    = $clog2(SLOTS)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           valid,
  input  logic           mode,
  input  logic [NCH-1:0] empty,
  input  logic           dst_full,
  input  logic           cfg_we,
  input  logic [SW-1:0]  cfg_addr,
  input  logic [IDW-1:0] cfg_id,
  input  logic           cfg_len_we,
  input  logic [SW:0]    cfg_len,
  output logic           read,
  output logic [IDW-1:0] pop_id,
  output logic [SW-1:0]  slot_ptr
);

  logic [SLOTS-1:0][IDW-1:0] tbl;
  logic [SW:0]               len;
  logic [SW-1:0]             ptr;
  logic                      hit;
  logic [SW-1:0]             sel;
  logic                      eval;

  assign eval     = valid && !dst_full;
  assign slot_ptr = ptr;

  // Step to the following slot, wrapping at the active length
  function automatic logic [SW-1:0] advance(input logic [SW-1:0] idx, input logic [SW:0] l);
    logic [SW:0] nxt;
    nxt = {1'b0, idx} + (SW+1)'(1);
    return (nxt >= l) ? '0 : nxt[SW-1:0];
  endfunction

  rr_slot_picker #(
    .NCH   (NCH),
    .SLOTS (SLOTS),
    .IDW   (IDW),
    .SW    (SW)
  ) u_picker (
    .tbl   (tbl),
    .len   (len),
    .ptr   (ptr),
    .empty (empty),
    .mode  (mode),
    .hit   (hit),
    .sel   (sel)
  );

  // Slot table and active length; writes land after this edge's evaluation
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SLOTS; i++) tbl[i] <= IDW'(default_id(i, NCH));
      len <= (SW+1)'(SLOTS);
    end else begin
      if (cfg_we && int'(cfg_addr) < SLOTS) tbl[cfg_addr] <= cfg_id;
      if (cfg_len_we && cfg_len != '0 && int'(cfg_len) <= SLOTS) len <= cfg_len;
    end
  end

  // Grant register and pointer; strict mode always advances, work-conserving only on a hit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read   <= 1'b0;
      pop_id <= '0;
      ptr    <= '0;
    end else if (eval) begin
      read <= hit;
      if (hit) pop_id <= tbl[sel];
      if (hit || mode == MODE_STRICT) ptr <= advance(sel, len);
    end else begin
      read <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_slot_scheduler.sv
// tb/tb_rr_slot_scheduler.sv - directed self-checking bench for rr_slot_scheduler
module tb_rr_slot_scheduler;

  localparam int NCH   = 4;
  localparam int SLOTS = 10;
  localparam int IDW   = 2;
  localparam int SW    = 4;

  logic           clk;
  logic           reset;
  logic           valid;
  logic           mode;
  logic [NCH-1:0] empty;
  logic           dst_full;
  logic           cfg_we;
  logic [SW-1:0]  cfg_addr;
  logic [IDW-1:0] cfg_id;
  logic           cfg_len_we;
  logic [SW:0]    cfg_len;
  logic           read;
  logic [IDW-1:0] pop_id;
  logic [SW-1:0]  slot_ptr;

  int checks = 0;
  int errors = 0;

  int def_tbl [10] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1};
  int wc_id   [8]  = '{2, 3, 0, 2, 3, 0, 0, 2};
  int wc_ptr  [8]  = '{3, 4, 5, 7, 8, 9, 1, 3};
  int l3_id   [6]  = '{2, 2, 1, 2, 2, 1};
  int l3_ptr  [6]  = '{1, 2, 0, 1, 2, 0};
  int last_id;

  rr_slot_scheduler #(
    .NCH   (NCH),
    .SLOTS (SLOTS),
    .IDW   (IDW),
    .SW    (SW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .valid      (valid),
    .mode       (mode),
    .empty      (empty),
    .dst_full   (dst_full),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_id     (cfg_id),
    .cfg_len_we (cfg_len_we),
    .cfg_len    (cfg_len),
    .read       (read),
    .pop_id     (pop_id),
    .slot_ptr   (slot_ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input int r, input int id, input int p);
    check({tag, ".read"}, 32'(read), 32'(r));
    check({tag, ".pop_id"}, 32'(pop_id), 32'(id));
    check({tag, ".slot_ptr"}, 32'(slot_ptr), 32'(p));
  endtask

  task automatic run_default_strict(input string tag);
    for (int k = 0; k < 12; k++) begin
      step();
      expect_out(tag, 1, def_tbl[k % 10], (k + 1) % 10);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; valid = 1'b0; mode = 1'b0; empty = '0; dst_full = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_id = '0; cfg_len_we = 1'b0; cfg_len = '0;
    #2;
    expect_out("reset", 0, 0, 0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    valid = 1'b1;

    run_default_strict("strict_all");

    empty = 4'b0010;
    last_id = 1;
    for (int k = 0; k < 10; k++) begin
      int s;
      int id;
      s  = (2 + k) % 10;
      id = def_tbl[s];
      step();
      if (id != 1) last_id = id;
      expect_out("strict_e1", (id != 1) ? 1 : 0, last_id, (s + 1) % 10);
    end

    mode = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      expect_out("wc_e1", 1, wc_id[k], wc_ptr[k]);
    end

    valid = 1'b0; empty = '0;
    cfg_len_we = 1'b1; cfg_len = 5'd3; cfg_we = 1'b1; cfg_addr = 4'd0; cfg_id = 2'd2;
    step();
    expect_out("cfg_idle", 0, 2, 3);
    cfg_len_we = 1'b0; cfg_addr = 4'd1; cfg_id = 2'd2;
    step();
    cfg_addr = 4'd2; cfg_id = 2'd1;
    step();
    cfg_we = 1'b0;
    cfg_len_we = 1'b1; cfg_len = 5'd0;
    step();
    cfg_len = 5'd11;
    step();
    cfg_len_we = 1'b0;
    check("cfg_hold.slot_ptr", 32'(slot_ptr), 32'd3);

    valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      expect_out("len3", 1, l3_id[k], l3_ptr[k]);
    end

    cfg_we = 1'b1; cfg_addr = 4'd0; cfg_id = 2'd3;
    step();
    expect_out("old_entry", 1, 2, 1);
    cfg_we = 1'b0;
    step();
    expect_out("new_entry_a", 1, 2, 2);
    step();
    expect_out("new_entry_b", 1, 1, 0);
    step();
    expect_out("new_entry_c", 1, 3, 1);

    empty = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      step();
      expect_out("all_empty", 0, 3, 1);
    end
    empty = 4'b0111;
    step();
    expect_out("wake_ch3", 1, 3, 1);

    empty = 4'b0000;
    step();
    expect_out("pre_full", 1, 2, 2);
    dst_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      expect_out("dst_full", 0, 2, 2);
    end
    dst_full = 1'b0;
    step();
    expect_out("resume_a", 1, 1, 0);
    step();
    expect_out("resume_b", 1, 3, 1);

    #3;
    reset = 1'b1;
    #1;
    expect_out("async_reset", 0, 0, 0);
    #1;
    reset = 1'b0;
    mode = 1'b0;
    run_default_strict("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_slot_scheduler.md
# rr_slot_scheduler

Parametrised slot-table round-robin pop scheduler for the FIFO bank. Each cycle it walks a programmable table of channel IDs, selects the next slot whose FIFO is non-empty, and issues a one-cycle `read` pulse with `pop_id` to the FIFO pop mux. It adds three things to the fixed 4-channel/10-slot scheduler:
- a runtime-writable table with programmable active length;
- strict and work-conserving modes;
- downstream back-pressure.

## Interface
- `NCH`, 4, number of FIFO channels (≥2)
- `SLOTS`, 10, physical slot-table depth (≥2)
- `IDW`, `$clog2(NCH)`, channel ID width
- `SW`, `$clog2(SLOTS)`, slot index width
- `clk`  in  1  single clock; all state on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `valid`  in  1  scheduling enable; no evaluation when low
- `mode`  in  1  0 = strict slot, 1 = work-conserving
- `empty`  in  NCH  per-channel FIFO empty flags
- `dst_full`  in  1  downstream full; blocks pops
- `cfg_we`  in  1  slot-table write strobe
- `cfg_addr`  in  SW  slot index to write
- `cfg_id`  in  IDW  channel ID to write
- `cfg_len_we`  in  1  active-length write strobe
- `cfg_len`  in  SW+1  active slots, valid range 1..SLOTS
- `read`  out  1  pop strobe, one cycle per grant
- `pop_id`  out  IDW  channel popped when `read`=1
- `slot_ptr`  out  SW  current table pointer

## Operation
- Reset state:
  - table[i] = i mod NCH; len = SLOTS; ptr = 0.
  - `read` = 0, `pop_id` = 0, `slot_ptr` = 0.
- Evaluation happens on every edge with `valid`=1 and `dst_full`=0:
  - Strict mode:
    - If empty[table[ptr]] = 0: grant that slot (`read` <= 1, `pop_id` <= table[ptr]).
    - Otherwise no grant (`read` <= 0).
    - ptr always advances by 1.
  - Work-conserving mode:
    - Search slots ptr, ptr+1, … over len entries with wrap, and take the first whose channel is non-empty.
    - On a grant: `read` <= 1, `pop_id` <= its ID, ptr <= sel+1.
    - If all len slots are empty: `read` <= 0, ptr unchanged.
- Advance: next = idx+1; if next ≥ len, next = 0. A ptr ≥ len (left over after len shrank) is treated as 0 at evaluation.
- No evaluation (`valid`=0 or `dst_full`=1): `read` <= 0; ptr and `pop_id` hold.
- Table write (`cfg_we`):
  - Writes table[cfg_addr] <= cfg_id on the edge.
  - A cfg_addr ≥ SLOTS is ignored.
  - Same-edge evaluation uses the old entry.
- Length write (`cfg_len_we`):
  - len <= cfg_len on the edge when 1 ≤ cfg_len ≤ SLOTS; other values are ignored.
  - Same-edge evaluation uses the old len.
- An ID ≥ NCH in the table counts as empty (never granted).
- Reset asserted mid-operation returns everything to the reset state immediately (async). The table is reloaded with its defaults.

## Timing
- Outputs are registered. Decision at edge N, `read`/`pop_id` valid during cycle N→N+1.
- Latency is 1 cycle from `empty`/`valid` to `read`.
- Maximum throughput is one grant per cycle. Back-to-back grants, including to the same channel, are allowed.
- `read` is never asserted in the cycle after an edge where `dst_full`=1 was sampled.
- The requester must deassert `empty` in reaction to `read` before the next edge. The scheduler does not track in-flight pops.
- Work-conserving search is combinational over SLOTS entries within a single cycle.

## Structure
- Shared package `rr_sched_pkg`:
  - mode constants `MODE_STRICT`=0, `MODE_WC`=1;
  - default-table function (i mod NCH).
- Sub-module `rr_slot_picker`: combinational rotate-priority search.
  - Inputs: table, len, ptr, empty, mode.
  - Outputs: hit, sel index.
- Top holds the table, len, ptr and output registers.

## Test plan
- Reset, strict mode, `empty`=4'b0000, `valid`=1 for 12 cycles -> `pop_id` sequence 0,1,2,3,0,1,2,3,0,1,0,1; `slot_ptr` wraps 9→0.
- Strict mode, `empty`=4'b0010 -> slots holding ID 1 produce `read`=0 for that cycle while ptr still advances. Work-conserving mode with the same input -> `read` stays 1 continuously with IDs 0,2,3,0,2,3,….
- Write `cfg_len`=3 and table[0..2]=2,2,1; run work-conserving with `empty`=0 -> `pop_id` 2,2,1,2,2,1. Writing `cfg_len`=0 or 11 -> len unchanged.
- All empty in work-conserving mode -> `read`=0 and ptr frozen. Clear empty[3] -> `read` on the next cycle with `pop_id`=3.
- `dst_full`=1 for 3 cycles mid-run -> `read`=0 and ptr/`pop_id` hold. Release -> the sequence resumes from the held slot.
- Assert `reset` asynchronously between edges mid-run -> `read`=0 and ptr=0 immediately; the table and len return to defaults.
